// File: rtl/vram_arbiter_nport_if.sv
// Request/grant/read-data bundle between NCH VRAM clients and the shared-RAM arbiter.
// Channel i occupies addr[i*ADDR_W +: ADDR_W] and wdata[i*DATA_W +: DATA_W].
interface vram_arbiter_nport_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NCH    = 3
) ();
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        we;
    logic [NCH*ADDR_W-1:0] addr;
    logic [NCH*DATA_W-1:0] wdata;
    logic [NCH-1:0]        gnt;
    logic [NCH-1:0]        rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  busy;
    logic                  oob_err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, busy, oob_err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, busy, oob_err
    );
endinterface

// File: rtl/vram_arbiter_nport.sv
// Single-port VRAM shared by NCH clients: ch0 fixed priority, ch1..NCH-1 round-robin,
// zero-fill after reset, bounds-checked accesses with one-cycle registered read.
module vram_arbiter_nport #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 32768,
    parameter int NCH            = 3,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clock,
    input  logic               reset_N,
    vram_arbiter_nport_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NCH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    // Channel index visited k steps after ptr in the 1..NCH-1 ring (ch0 never in ring).
    function automatic logic [CH_W-1:0] rr_cand(input logic [CH_W-1:0] ptr, input int k);
        int c;
        c = int'(ptr) + k;
        if (c > NCH - 1) begin
            c = c - (NCH - 1);
        end
        return CH_W'(c);
    endfunction

    // ------------------------------------------------------------------
    // Per-channel unpacking and range check
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] ch_addr  [NCH];
    logic [DATA_W-1:0] ch_wdata [NCH];
    logic [NCH-1:0]    ch_oob;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_addr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = bus.wdata[gi*DATA_W +: DATA_W];
            assign ch_oob[gi]   = ({1'b0, ch_addr[gi]} >= DEPTH_EXT);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clear_cnt_q, clear_cnt_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NCH-1:0]    rvalid_q, rvalid_d;
    logic              oob_err_q, oob_err_d;
    logic              rd_zero_q, rd_zero_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_dout_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NCH-1:0]    gnt_vec;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;

    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (reset_N && (state_q == ST_RUN)) begin
            if (bus.req[0]) begin
                gnt_any = 1'b1;
                gnt_idx = '0;
            end else begin
                for (int k = 1; k < NCH; k++) begin
                    if (!gnt_any && bus.req[rr_cand(rr_ptr_q, k)]) begin
                        gnt_any = 1'b1;
                        gnt_idx = rr_cand(rr_ptr_q, k);
                    end
                end
            end
            if (gnt_any) begin
                gnt_vec[gnt_idx] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Granted-channel datapath and RAM port control
    // ------------------------------------------------------------------
    logic              sel_we;
    logic              sel_oob;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [IDX_W-1:0]  ram_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_en;

    assign sel_we    = bus.we[gnt_idx];
    assign sel_oob   = ch_oob[gnt_idx];
    assign sel_addr  = ch_addr[gnt_idx];
    assign sel_wdata = ch_wdata[gnt_idx];
    assign ram_idx   = sel_addr[IDX_W-1:0];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        rd_en     = 1'b0;
        if (reset_N) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clear_cnt_q;
            end else if (gnt_any && !sel_oob) begin
                mem_we    = sel_we;
                mem_waddr = ram_idx;
                mem_wdata = sel_wdata;
                rd_en     = !sel_we;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rvalid_d    = '0;
        oob_err_d   = 1'b0;
        rd_zero_d   = rd_zero_q;
        case (state_q)
            ST_CLEAR: begin
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gnt_any) begin
                    oob_err_d = sel_oob;
                    if (!sel_we) begin
                        rvalid_d  = gnt_vec;
                        rd_zero_d = sel_oob;
                    end
                    if (gnt_idx != '0) begin
                        rr_ptr_d = gnt_idx;
                    end
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            state_q     <= RESET_STATE;
            clear_cnt_q <= '0;
            rr_ptr_q    <= LAST_CH;
            rvalid_q    <= '0;
            oob_err_q   <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rvalid_q    <= rvalid_d;
            oob_err_q   <= oob_err_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    // RAM array kept reset-free so it maps onto a block RAM; rd_zero_q masks stale output.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            ram_dout_q <= mem[ram_idx];
        end
    end

    assign bus.gnt     = gnt_vec;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rd_zero_q ? '0 : ram_dout_q;
    assign bus.busy    = (state_q == ST_CLEAR);
    assign bus.oob_err = oob_err_q;

endmodule

// File: tb/tb_vram_arbiter_nport.sv
// Directed bench: dut_a is DEPTH=16 with clear-on-reset, dut_b is DEPTH=32768 without it.
module tb_vram_arbiter_nport;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    vram_arbiter_nport_if #(.ADDR_W(16), .DATA_W(16), .NCH(3)) bus_a ();
    vram_arbiter_nport_if #(.ADDR_W(16), .DATA_W(16), .NCH(3)) bus_b ();

    vram_arbiter_nport #(.ADDR_W(16), .DATA_W(16), .DEPTH(16), .NCH(3), .CLEAR_ON_RESET(1)) dut_a (
        .clock   (clk),
        .reset_N (rst_a_n),
        .bus     (bus_a)
    );

    vram_arbiter_nport #(.ADDR_W(16), .DATA_W(16), .DEPTH(32768), .NCH(3), .CLEAR_ON_RESET(0)) dut_b (
        .clock   (clk),
        .reset_N (rst_b_n),
        .bus     (bus_b)
    );

    // One access on one channel: drive, wait for gnt (bounded), drop req, sample the cycle after.
    task automatic xfer(input bit on_b, input int ch, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output logic granted, output int waited,
                        output logic [2:0] rv, output logic [15:0] rd, output logic oe);
        waited = 0;
        if (on_b) begin
            bus_b.req[ch] = 1'b1; bus_b.we[ch] = w;
            bus_b.addr[ch*16 +: 16] = a; bus_b.wdata[ch*16 +: 16] = d;
        end else begin
            bus_a.req[ch] = 1'b1; bus_a.we[ch] = w;
            bus_a.addr[ch*16 +: 16] = a; bus_a.wdata[ch*16 +: 16] = d;
        end
        #1;
        granted = on_b ? bus_b.gnt[ch] : bus_a.gnt[ch];
        while (!granted && waited < 64) begin
            @(negedge clk); #1;
            waited++;
            granted = on_b ? bus_b.gnt[ch] : bus_a.gnt[ch];
        end
        @(negedge clk);
        if (on_b) bus_b.req[ch] = 1'b0; else bus_a.req[ch] = 1'b0;
        #1;
        rv = on_b ? bus_b.rvalid  : bus_a.rvalid;
        rd = on_b ? bus_b.rdata   : bus_a.rdata;
        oe = on_b ? bus_b.oob_err : bus_a.oob_err;
        $display("[TB] dut_%s ch%0d %s addr=%h wdata=%h gnt=%0b wait=%0d rvalid=%b rdata=%h oob=%0b",
                 on_b ? "b" : "a", ch, w ? "WR" : "RD", a, d, granted, waited, rv, rd, oe);
    endtask

    task automatic test_reset();
        bus_a.req = 3'b111; bus_a.we = 3'b000; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 3'b010; bus_b.we = 3'b000; bus_b.addr = '0; bus_b.wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (bus_a.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt_a got=%b exp=000", bus_a.gnt); end
        n_tests++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_a got=%b exp=1", bus_a.busy); end
        n_tests++; if (bus_a.rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid_a got=%b exp=000", bus_a.rvalid); end
        n_tests++; if (bus_a.rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata_a got=%h exp=0000", bus_a.rdata); end
        n_tests++; if (bus_a.oob_err !== 1'b0) begin n_fail++; $display("FAIL reset_oob_a got=%b exp=0", bus_a.oob_err); end
        n_tests++; if (bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b got=%b exp=0", bus_b.busy); end
        n_tests++; if (bus_b.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt_b got=%b exp=000", bus_b.gnt); end
        bus_a.req = 3'b000;
        bus_b.req = 3'b000;
    endtask

    // Release reset with a ch1 read held: no grant while clearing, then granted at once.
    task automatic test_clear_hold();
        int  cyc = 0;
        bit  gnt_seen = 0;
        @(negedge clk);
        bus_a.req = 3'b010; bus_a.we = 3'b000; bus_a.addr = '0;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        #1;
        while (bus_a.busy && cyc < 100) begin
            cyc++;
            if (bus_a.gnt !== 3'b000) gnt_seen = 1;
            @(negedge clk); #1;
        end
        n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL clear_busy_len got=%0d exp=16", cyc); end
        n_tests++; if (gnt_seen) begin n_fail++; $display("FAIL clear_no_gnt got=1 exp=0"); end
        n_tests++; if (bus_a.gnt !== 3'b010) begin n_fail++; $display("FAIL clear_held_req_gnt got=%b exp=010", bus_a.gnt); end
        @(negedge clk);
        bus_a.req = 3'b000;
        #1;
        n_tests++; if (bus_a.rvalid !== 3'b010) begin n_fail++; $display("FAIL clear_held_rvalid got=%b exp=010", bus_a.rvalid); end
    endtask

    task automatic test_clear();
        logic g, oe; int wt; logic [2:0] rv; logic [15:0] rd;
        int cyc = 0;
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1, 1'b1, 16'(i), 16'hFFFF, g, wt, rv, rd, oe);
            n_tests++; if (g !== 1'b1) begin n_fail++; $display("FAIL preload_gnt addr=%0d got=%b exp=1", i, g); end
        end
        xfer(0, 1, 1'b0, 16'd9, 16'h0, g, wt, rv, rd, oe);
        n_tests++; if (rd !== 16'hFFFF) begin n_fail++; $display("FAIL preload_readback got=%h exp=ffff", rd); end
        @(negedge clk); rst_a_n = 1'b0;
        @(negedge clk); rst_a_n = 1'b1;
        #1;
        while (bus_a.busy && cyc < 100) begin
            cyc++;
            @(negedge clk); #1;
        end
        n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL reclear_busy_len got=%0d exp=16", cyc); end
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1, 1'b0, 16'(i), 16'h0, g, wt, rv, rd, oe);
            n_tests++;
            if (rv !== 3'b010 || rd !== 16'h0000) begin
                n_fail++; $display("FAIL clear_zero addr=%0d got rvalid=%b rdata=%h exp rvalid=010 rdata=0000", i, rv, rd);
            end
        end
    endtask

    task automatic test_write_read();
        logic g, oe; int wt; logic [2:0] rv; logic [15:0] rd;
        xfer(0, 1, 1'b1, 16'h0005, 16'hBEEF, g, wt, rv, rd, oe);
        n_tests++; if (g !== 1'b1 || wt != 0) begin n_fail++; $display("FAIL wr_gnt got gnt=%b wait=%0d exp gnt=1 wait=0", g, wt); end
        n_tests++; if (rv !== 3'b000) begin n_fail++; $display("FAIL wr_no_rvalid got=%b exp=000", rv); end
        xfer(0, 1, 1'b0, 16'h0005, 16'h0000, g, wt, rv, rd, oe);
        n_tests++; if (g !== 1'b1 || wt != 0) begin n_fail++; $display("FAIL rd_gnt got gnt=%b wait=%0d exp gnt=1 wait=0", g, wt); end
        n_tests++; if (rv !== 3'b010) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=010", rv); end
        n_tests++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL rd_rdata got=%h exp=beef", rd); end
        n_tests++; if (oe !== 1'b0) begin n_fail++; $display("FAIL rd_oob got=%b exp=0", oe); end
        @(negedge clk); #1;
        n_tests++; if (bus_a.rvalid !== 3'b000) begin n_fail++; $display("FAIL rd_rvalid_drop got=%b exp=000", bus_a.rvalid); end
    endtask

    task automatic test_priority_rr();
        logic g, oe; int wt; logic [2:0] rv; logic [15:0] rd;
        logic [2:0]  exp_gnt [3];
        logic [2:0]  exp_rv  [3];
        logic [15:0] exp_rd  [3];
        exp_gnt = '{3'b010, 3'b100, 3'b010};
        exp_rv  = '{3'b001, 3'b010, 3'b100};
        exp_rd  = '{16'hBEEF, 16'h0000, 16'h0000};
        // A ch2 grant leaves the ring pointer at 2, so the ring restarts at ch1.
        xfer(0, 2, 1'b0, 16'h0007, 16'h0, g, wt, rv, rd, oe);
        n_tests++; if (g !== 1'b1) begin n_fail++; $display("FAIL rr_setup_gnt got=%b exp=1", g); end
        bus_a.we = 3'b000;
        bus_a.addr = {16'h0007, 16'h0003, 16'h0005};
        bus_a.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (bus_a.gnt !== 3'b001) begin n_fail++; $display("FAIL prio_gnt cyc=%0d got=%b exp=001", i, bus_a.gnt); end
            if (i > 0) begin
                n_tests++;
                if (bus_a.rvalid !== 3'b001 || bus_a.rdata !== 16'hBEEF) begin
                    n_fail++; $display("FAIL prio_b2b cyc=%0d got rvalid=%b rdata=%h exp rvalid=001 rdata=beef", i, bus_a.rvalid, bus_a.rdata);
                end
            end
            @(negedge clk);
        end
        bus_a.req[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_tests++; if (bus_a.gnt !== exp_gnt[j]) begin n_fail++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", j, bus_a.gnt, exp_gnt[j]); end
            n_tests++;
            if (bus_a.rvalid !== exp_rv[j] || bus_a.rdata !== exp_rd[j]) begin
                n_fail++; $display("FAIL rr_rvalid step=%0d got rvalid=%b rdata=%h exp rvalid=%b rdata=%h", j, bus_a.rvalid, bus_a.rdata, exp_rv[j], exp_rd[j]);
            end
            @(negedge clk);
        end
        bus_a.req = 3'b000;
        #1;
        n_tests++; if (bus_a.rvalid !== 3'b010) begin n_fail++; $display("FAIL rr_last_rvalid got=%b exp=010", bus_a.rvalid); end
    endtask

    task automatic test_reset_mid_clear();
        int cyc = 0;
        bit gnt_seen = 0;
        @(negedge clk); rst_a_n = 1'b0;
        @(negedge clk); rst_a_n = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        n_tests++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy got=%b exp=1", bus_a.busy); end
        rst_a_n = 1'b0;
        bus_a.we = 3'b000; bus_a.addr = {16'h0, 16'h0005, 16'h0}; bus_a.req = 3'b010;
        #1;
        n_tests++; if (bus_a.gnt !== 3'b000) begin n_fail++; $display("FAIL midclr_reset_gnt got=%b exp=000", bus_a.gnt); end
        @(negedge clk);
        rst_a_n = 1'b1;
        #1;
        while (bus_a.busy && cyc < 100) begin
            cyc++;
            if (bus_a.gnt !== 3'b000) gnt_seen = 1;
            @(negedge clk); #1;
        end
        n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL midclr_busy_len got=%0d exp=16", cyc); end
        n_tests++; if (gnt_seen) begin n_fail++; $display("FAIL midclr_no_gnt got=1 exp=0"); end
        n_tests++; if (bus_a.rvalid !== 3'b000) begin n_fail++; $display("FAIL midclr_no_rvalid got=%b exp=000", bus_a.rvalid); end
        n_tests++; if (bus_a.gnt !== 3'b010) begin n_fail++; $display("FAIL midclr_gnt got=%b exp=010", bus_a.gnt); end
        @(negedge clk);
        bus_a.req = 3'b000;
        #1;
        n_tests++;
        if (bus_a.rvalid !== 3'b010 || bus_a.rdata !== 16'h0000) begin
            n_fail++; $display("FAIL midclr_wiped got rvalid=%b rdata=%h exp rvalid=010 rdata=0000", bus_a.rvalid, bus_a.rdata);
        end
    endtask

    task automatic test_oob();
        logic g, oe; int wt; logic [2:0] rv; logic [15:0] rd;
        xfer(1, 2, 1'b1, 16'h0000, 16'h5A5A, g, wt, rv, rd, oe);
        n_tests++; if (g !== 1'b1 || oe !== 1'b0) begin n_fail++; $display("FAIL oob_pre_wr got gnt=%b oob=%b exp gnt=1 oob=0", g, oe); end
        xfer(1, 2, 1'b1, 16'h8000, 16'h1234, g, wt, rv, rd, oe);
        n_tests++; if (g !== 1'b1) begin n_fail++; $display("FAIL oob_wr_gnt got=%b exp=1", g); end
        n_tests++; if (oe !== 1'b1) begin n_fail++; $display("FAIL oob_wr_err got=%b exp=1", oe); end
        n_tests++; if (rv !== 3'b000) begin n_fail++; $display("FAIL oob_wr_rvalid got=%b exp=000", rv); end
        @(negedge clk); #1;
        n_tests++; if (bus_b.oob_err !== 1'b0) begin n_fail++; $display("FAIL oob_pulse_len got=%b exp=0", bus_b.oob_err); end
        xfer(1, 2, 1'b0, 16'h8000, 16'h0, g, wt, rv, rd, oe);
        n_tests++; if (oe !== 1'b1) begin n_fail++; $display("FAIL oob_rd_err got=%b exp=1", oe); end
        n_tests++; if (rv !== 3'b100 || rd !== 16'h0000) begin n_fail++; $display("FAIL oob_rd_data got rvalid=%b rdata=%h exp rvalid=100 rdata=0000", rv, rd); end
        xfer(1, 2, 1'b0, 16'h0000, 16'h0, g, wt, rv, rd, oe);
        n_tests++; if (rv !== 3'b100 || rd !== 16'h5A5A) begin n_fail++; $display("FAIL oob_alias_intact got rvalid=%b rdata=%h exp rvalid=100 rdata=5a5a", rv, rd); end
        n_tests++; if (oe !== 1'b0) begin n_fail++; $display("FAIL oob_inrange_err got=%b exp=0", oe); end
        xfer(1, 1, 1'b1, 16'h7FFF, 16'h7777, g, wt, rv, rd, oe);
        n_tests++; if (oe !== 1'b0) begin n_fail++; $display("FAIL oob_top_wr_err got=%b exp=0", oe); end
        xfer(1, 1, 1'b0, 16'h7FFF, 16'h0, g, wt, rv, rd, oe);
        n_tests++; if (rv !== 3'b010 || rd !== 16'h7777) begin n_fail++; $display("FAIL oob_top_rd got rvalid=%b rdata=%h exp rvalid=010 rdata=7777", rv, rd); end
    endtask

    task automatic test_no_clear();
        @(negedge clk);
        rst_b_n = 1'b0;
        bus_b.we = 3'b000; bus_b.addr = '0; bus_b.req = 3'b010;
        #1;
        n_tests++; if (bus_b.gnt !== 3'b000) begin n_fail++; $display("FAIL noclr_reset_gnt got=%b exp=000", bus_b.gnt); end
        @(negedge clk);
        rst_b_n = 1'b1;
        #1;
        n_tests++; if (bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL noclr_busy got=%b exp=0", bus_b.busy); end
        n_tests++; if (bus_b.rvalid !== 3'b000) begin n_fail++; $display("FAIL noclr_no_rvalid got=%b exp=000", bus_b.rvalid); end
        n_tests++; if (bus_b.gnt !== 3'b010) begin n_fail++; $display("FAIL noclr_first_gnt got=%b exp=010", bus_b.gnt); end
        @(negedge clk);
        bus_b.req = 3'b000;
        #1;
        n_tests++;
        if (bus_b.rvalid !== 3'b010 || bus_b.rdata !== 16'h5A5A) begin
            n_fail++; $display("FAIL noclr_rd got rvalid=%b rdata=%h exp rvalid=010 rdata=5a5a", bus_b.rvalid, bus_b.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_clear_hold();
        test_clear();
        test_write_read();
        test_priority_rr();
        test_reset_mid_clear();
        test_oob();
        test_no_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
